// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-producer result FIFOs drained one entry
// per cycle onto a registered broadcast bus by a round-robin scheduler.

`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

module cdb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_W      = `ROB_ENTRY_WIDTH,
    parameter int DATA_W     = 32,
    localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rollback,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ROB_W-1:0]  req_rob_index,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [ROB_W-1:0]          cdb_rob_index,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Per-requester status and head-of-queue views, flattened for the scheduler.
    logic [NUM_REQ-1:0]        non_empty;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ*ROB_W-1:0]  head_rob;
    logic [NUM_REQ*DATA_W-1:0] head_data;

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  winner;
    logic              found;
    logic [SRC_W-1:0]  rr_next;
    logic [ROB_W-1:0]  win_rob;
    logic [DATA_W-1:0] win_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
            logic [ROB_W-1:0]  rob_mem  [FIFO_DEPTH];
            logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
            logic [PTR_W-1:0]  wr_ptr;
            logic [PTR_W-1:0]  rd_ptr;
            logic [CNT_W-1:0]  count;
            logic [ROB_W-1:0]  in_rob;
            logic [DATA_W-1:0] in_data;
            logic              push;
            logic              pop;

            assign in_rob  = req_rob_index[gi*ROB_W +: ROB_W];
            assign in_data = req_data[gi*DATA_W +: DATA_W];

            // Ready depends only on the registered count, so a full FIFO
            // never accepts on the strength of a same-cycle pop.
            assign req_ready[gi] = (count != CNT_W'(FIFO_DEPTH));
            assign non_empty[gi] = (count != '0);

            // A zero ROB index means "no result" and is silently dropped.
            assign push = req_valid[gi] && req_ready[gi] && (in_rob != '0);
            assign pop  = grant[gi];

            assign head_rob[gi*ROB_W +: ROB_W]    = rob_mem[rd_ptr];
            assign head_data[gi*DATA_W +: DATA_W] = data_mem[rd_ptr];

            // Storage array: written at the tail, no reset needed since
            // the count gates every read.
            always_ff @(posedge clk) begin
                if (push && !rollback) begin
                    rob_mem[wr_ptr]  <= in_rob;
                    data_mem[wr_ptr] <= in_data;
                end
            end

            // Pointer and occupancy tracking; rollback flushes everything.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else if (rollback) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                    unique case ({push, pop})
                        2'b10:   count <= count + CNT_W'(1);
                        2'b01:   count <= count - CNT_W'(1);
                        default: count <= count;
                    endcase
                end
            end
        end
    endgenerate

    // Round-robin scan starting at rr_ptr; first non-empty FIFO wins.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && non_empty[idx]) begin
                found  = 1'b1;
                winner = SRC_W'(idx);
            end
        end
    end

    // One-hot pop strobe for the winning FIFO, suppressed during rollback.
    always_comb begin
        grant = '0;
        if (found && !rollback) begin
            grant[winner] = 1'b1;
        end
    end

    // Head of the winning queue and the pointer for the next scan.
    always_comb begin
        win_rob  = head_rob[winner*ROB_W +: ROB_W];
        win_data = head_data[winner*DATA_W +: DATA_W];
        if (winner == SRC_W'(NUM_REQ - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = winner + SRC_W'(1);
        end
    end

    // Registered broadcast bus and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            cdb_valid     <= 1'b0;
            cdb_rob_index <= '0;
            cdb_data      <= '0;
            cdb_src       <= '0;
        end else if (rollback) begin
            rr_ptr        <= '0;
            cdb_valid     <= 1'b0;
            cdb_rob_index <= '0;
            cdb_data      <= '0;
            cdb_src       <= '0;
        end else if (found) begin
            rr_ptr        <= rr_next;
            cdb_valid     <= 1'b1;
            cdb_rob_index <= win_rob;
            cdb_data      <= win_data;
            cdb_src       <= winner;
        end else begin
            cdb_valid     <= 1'b0;
            cdb_rob_index <= '0;
            cdb_data      <= '0;
            cdb_src       <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin order,
// backpressure, rollback flush and zero-index filtering.

module tb_cdb_arbiter;

    localparam int NREQ = 3;
    localparam int RW   = 6;
    localparam int DW   = 32;

    logic            clk;
    logic            rst;
    logic            rollback;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*RW-1:0] req_rob_index;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic            cdb_valid;
    logic [RW-1:0]   cdb_rob_index;
    logic [DW-1:0]   cdb_data;
    logic [1:0]      cdb_src;

    int checks;
    int failures;

    cdb_arbiter #(
        .NUM_REQ(NREQ),
        .FIFO_DEPTH(2),
        .ROB_W(RW),
        .DATA_W(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rollback(rollback),
        .req_valid(req_valid),
        .req_rob_index(req_rob_index),
        .req_data(req_data),
        .req_ready(req_ready),
        .cdb_valid(cdb_valid),
        .cdb_rob_index(cdb_rob_index),
        .cdb_data(cdb_data),
        .cdb_src(cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cdb(input string tag, input logic v,
                           input logic [RW-1:0] rob,
                           input logic [DW-1:0] dat,
                           input logic [1:0] src);
        chk({tag, ".valid"}, 64'(cdb_valid), 64'(v));
        chk({tag, ".rob"}, 64'(cdb_rob_index), 64'(rob));
        chk({tag, ".data"}, 64'(cdb_data), 64'(dat));
        chk({tag, ".src"}, 64'(cdb_src), 64'(src));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [RW-1:0] rob,
                       input logic [DW-1:0] dat);
        req_valid[i] = 1'b1;
        req_rob_index[i*RW +: RW] = rob;
        req_data[i*DW +: DW] = dat;
    endtask

    task automatic clr();
        req_valid = '0;
        req_rob_index = '0;
        req_data = '0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        rollback = 1'b0;
        clr();
        #2;
        chk_cdb("reset", 1'b0, '0, '0, '0);
        chk("reset.ready", 64'(req_ready), 64'(3'b111));
        #1;
        rst = 1'b0;

        // single path
        put(0, 6'd5, 32'hDEAD_BEEF);
        tick();
        chk("single.no_bypass", 64'(cdb_valid), 64'd0);
        clr();
        tick();
        chk_cdb("single.bcast", 1'b1, 6'd5, 32'hDEAD_BEEF, 2'd0);
        tick();
        chk_cdb("single.idle", 1'b0, '0, '0, '0);

        // round robin
        pulse_rst();
        put(0, 6'd1, 32'h1001);
        put(1, 6'd3, 32'h1003);
        put(2, 6'd6, 32'h1006);
        tick();
        chk("rr.first_idle", 64'(cdb_valid), 64'd0);
        clr();
        put(0, 6'd2, 32'h1002);
        put(1, 6'd4, 32'h1004);
        tick();
        clr();
        chk_cdb("rr.b0", 1'b1, 6'd1, 32'h1001, 2'd0);
        tick();
        chk_cdb("rr.b1", 1'b1, 6'd3, 32'h1003, 2'd1);
        tick();
        chk_cdb("rr.b2", 1'b1, 6'd6, 32'h1006, 2'd2);
        tick();
        chk_cdb("rr.b3", 1'b1, 6'd2, 32'h1002, 2'd0);
        tick();
        chk_cdb("rr.b4", 1'b1, 6'd4, 32'h1004, 2'd1);
        tick();
        chk_cdb("rr.idle", 1'b0, '0, '0, '0);

        // backpressure on LSQ while ALU competes
        pulse_rst();
        put(0, 6'd10, 32'hA010);
        put(1, 6'd20, 32'hB020);
        tick();
        chk("bp.e1", 64'(cdb_valid), 64'd0);
        put(0, 6'd11, 32'hA011);
        put(1, 6'd21, 32'hB021);
        tick();
        chk_cdb("bp.e2", 1'b1, 6'd10, 32'hA010, 2'd0);
        chk("bp.e2.ready", 64'(req_ready), 64'(3'b101));
        put(0, 6'd12, 32'hA012);
        put(1, 6'd22, 32'hB022);
        tick();
        chk_cdb("bp.e3", 1'b1, 6'd20, 32'hB020, 2'd1);
        chk("bp.e3.ready", 64'(req_ready), 64'(3'b110));
        put(0, 6'd13, 32'hA013);
        tick();
        chk_cdb("bp.e4", 1'b1, 6'd11, 32'hA011, 2'd0);
        chk("bp.e4.ready", 64'(req_ready), 64'(3'b101));
        put(1, 6'd23, 32'hB023);
        tick();
        chk_cdb("bp.e5", 1'b1, 6'd21, 32'hB021, 2'd1);
        chk("bp.e5.ready", 64'(req_ready), 64'(3'b110));
        clr();
        tick();
        chk_cdb("bp.d0", 1'b1, 6'd12, 32'hA012, 2'd0);
        tick();
        chk_cdb("bp.d1", 1'b1, 6'd22, 32'hB022, 2'd1);
        tick();
        chk_cdb("bp.d2", 1'b1, 6'd13, 32'hA013, 2'd0);
        tick();
        chk_cdb("bp.idle", 1'b0, '0, '0, '0);

        // rollback flush
        pulse_rst();
        put(0, 6'd30, 32'hC030);
        put(1, 6'd40, 32'hC040);
        tick();
        put(0, 6'd31, 32'hC031);
        put(1, 6'd41, 32'hC041);
        tick();
        chk_cdb("rb.pre", 1'b1, 6'd30, 32'hC030, 2'd0);
        clr();
        rollback = 1'b1;
        put(0, 6'd32, 32'hC032);
        put(2, 6'd50, 32'hC050);
        tick();
        chk_cdb("rb.flush", 1'b0, '0, '0, '0);
        chk("rb.ready", 64'(req_ready), 64'(3'b111));
        rollback = 1'b0;
        clr();
        tick();
        chk_cdb("rb.empty", 1'b0, '0, '0, '0);
        put(0, 6'd33, 32'hC033);
        put(2, 6'd51, 32'hC051);
        tick();
        clr();
        tick();
        chk_cdb("rb.rr0", 1'b1, 6'd33, 32'hC033, 2'd0);
        tick();
        chk_cdb("rb.next", 1'b1, 6'd51, 32'hC051, 2'd2);
        tick();
        chk_cdb("rb.idle", 1'b0, '0, '0, '0);

        // zero index is ignored
        put(0, 6'd0, 32'h5555_AAAA);
        tick();
        chk("zero.ready1", 64'(req_ready[0]), 64'd1);
        tick();
        chk("zero.ready2", 64'(req_ready[0]), 64'd1);
        chk_cdb("zero.idle1", 1'b0, '0, '0, '0);
        tick();
        chk_cdb("zero.idle2", 1'b0, '0, '0, '0);
        chk("zero.ready3", 64'(req_ready[0]), 64'd1);
        clr();

        // async reset mid-burst
        put(0, 6'd7, 32'hE007);
        put(1, 6'd8, 32'hE008);
        tick();
        tick();
        chk_cdb("mid.pre", 1'b1, 6'd7, 32'hE007, 2'd0);
        rst = 1'b1;
        #1;
        chk_cdb("mid.async", 1'b0, '0, '0, '0);
        chk("mid.ready", 64'(req_ready), 64'(3'b111));
        clr();
        #1;
        rst = 1'b0;
        tick();
        chk_cdb("mid.idle1", 1'b0, '0, '0, '0);
        tick();
        chk_cdb("mid.idle2", 1'b0, '0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
